// File: rtl/game_pkg.sv
// Shared game constants, coordinate widths and state encodings for the
// road-crossing game (round controller, vga, car_ctrl, raccoon_ctrl).
package game_pkg;

    localparam int unsigned X_W        = 10;
    localparam int unsigned CAR_Y_W    = 9;
    localparam int unsigned PLAYER_Y_W = 10;
    localparam int unsigned SUM_W      = 11;
    localparam int unsigned LIVES_W    = 4;
    localparam int unsigned LEVEL_W    = 4;
    localparam int unsigned GRACE_W    = 8;
    localparam int unsigned IDX_W      = 4;

    localparam int unsigned SPRITE_CAR_W    = 32;
    localparam int unsigned SPRITE_CAR_H    = 32;
    localparam int unsigned SPRITE_PLAYER_W = 32;
    localparam int unsigned SPRITE_PLAYER_H = 32;

    typedef enum logic [1:0] {
        GS_IDLE = 2'b00,
        GS_RUN  = 2'b01,
        GS_WIN  = 2'b10,
        GS_OVER = 2'b11
    } game_state_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SCAN,
        ST_RESOLVE,
        ST_WIN,
        ST_OVER
    } round_state_e;

    typedef struct packed {
        logic [X_W-1:0]        x;
        logic [PLAYER_Y_W-1:0] y;
    } player_pos_t;

    // Scan and resolve are internal phases of a running round.
    function automatic game_state_e report_state(input round_state_e s);
        case (s)
            ST_IDLE: return GS_IDLE;
            ST_WIN:  return GS_WIN;
            ST_OVER: return GS_OVER;
            default: return GS_RUN;
        endcase
    endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap test between the raccoon and one car.
module aabb_overlap
    import game_pkg::*;
#(
    parameter int unsigned CAR_W    = SPRITE_CAR_W,
    parameter int unsigned CAR_H    = SPRITE_CAR_H,
    parameter int unsigned PLAYER_W = SPRITE_PLAYER_W,
    parameter int unsigned PLAYER_H = SPRITE_PLAYER_H
) (
    input  logic [X_W-1:0]        i_Player_X,
    input  logic [PLAYER_Y_W-1:0] i_Player_Y,
    input  logic [X_W-1:0]        i_Car_X,
    input  logic [CAR_Y_W-1:0]    i_Car_Y,
    output logic                  o_Overlap
);

    logic [SUM_W-1:0] px, py, cx, cy;

    // One extra bit keeps edge + size sums from wrapping near the screen edge.
    assign px = SUM_W'(i_Player_X);
    assign py = SUM_W'(i_Player_Y);
    assign cx = SUM_W'(i_Car_X);
    assign cy = SUM_W'(i_Car_Y);

    assign o_Overlap = (px < cx + SUM_W'(CAR_W))    &&
                       (px + SUM_W'(PLAYER_W) > cx) &&
                       (py < cy + SUM_W'(CAR_H))    &&
                       (py + SUM_W'(PLAYER_H) > cy);

endmodule

// File: rtl/hazard_round_ctrl.sv
// Round controller: per-frame time-multiplexed collision scan, lives, level,
// post-hit grace period and respawn requests.
module hazard_round_ctrl
    import game_pkg::*;
#(
    parameter int unsigned N_CARS       = 6,
    parameter int unsigned CAR_W        = SPRITE_CAR_W,
    parameter int unsigned CAR_H        = SPRITE_CAR_H,
    parameter int unsigned PLAYER_W     = SPRITE_PLAYER_W,
    parameter int unsigned PLAYER_H     = SPRITE_PLAYER_H,
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned MAX_LEVEL    = 9,
    parameter int unsigned GRACE_FRAMES = 60,
    parameter int unsigned GOAL_Y       = 0
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset,
    input  logic                        i_Start,
    input  logic                        i_Frame_Tick,
    input  logic [X_W-1:0]              i_Player_X,
    input  logic [PLAYER_Y_W-1:0]       i_Player_Y,
    input  logic [N_CARS*X_W-1:0]       i_Car_X,
    input  logic [N_CARS*CAR_Y_W-1:0]   i_Car_Y,
    output logic [1:0]                  o_Game_State,
    output logic [LIVES_W-1:0]          o_Lives,
    output logic [LEVEL_W-1:0]          o_Level,
    output logic                        o_Hit,
    output logic                        o_Respawn,
    output logic                        o_Invuln,
    output logic                        o_Busy
);

    round_state_e         state_q, state_d;
    player_pos_t          snap_q, snap_d;
    logic                 hit_q, hit_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [GRACE_W-1:0]   grace_q, grace_d;
    logic                 hit_pulse_q, hit_pulse_d;
    logic                 respawn_q, respawn_d;
    game_state_e          game_state_q;
    logic                 invuln_q, busy_q;

    logic [X_W-1:0]       car_x_c;
    logic [CAR_Y_W-1:0]   car_y_c;
    logic                 overlap_c;

    assign car_x_c = i_Car_X[32'(idx_q)*X_W +: X_W];
    assign car_y_c = i_Car_Y[32'(idx_q)*CAR_Y_W +: CAR_Y_W];

    aabb_overlap #(
        .CAR_W    (CAR_W),
        .CAR_H    (CAR_H),
        .PLAYER_W (PLAYER_W),
        .PLAYER_H (PLAYER_H)
    ) u_aabb (
        .i_Player_X (snap_q.x),
        .i_Player_Y (snap_q.y),
        .i_Car_X    (car_x_c),
        .i_Car_Y    (car_y_c),
        .o_Overlap  (overlap_c)
    );

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        hit_d       = hit_q;
        idx_d       = idx_q;
        lives_d     = lives_q;
        level_d     = level_q;
        grace_d     = grace_q;
        hit_pulse_d = 1'b0;
        respawn_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_WIN, ST_OVER: begin
                if (i_Start) begin
                    lives_d = LIVES_W'(START_LIVES);
                    level_d = '0;
                    grace_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_Frame_Tick) begin
                    snap_d  = '{x: i_Player_X, y: i_Player_Y};
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                    if (grace_q != '0) begin
                        grace_d = grace_q - GRACE_W'(1);
                    end
                end
            end
            ST_SCAN: begin
                hit_d = hit_q | overlap_c;
                if (idx_q == IDX_W'(N_CARS - 1)) begin
                    state_d = ST_RESOLVE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_RESOLVE: begin
                state_d = ST_RUN;
                // A hit absorbed by grace falls through so a goal still counts.
                if (hit_q && grace_q == '0) begin
                    lives_d     = lives_q - LIVES_W'(1);
                    hit_pulse_d = 1'b1;
                    if (lives_d == '0) begin
                        state_d = ST_OVER;
                    end else begin
                        respawn_d = 1'b1;
                        grace_d   = GRACE_W'(GRACE_FRAMES);
                    end
                end else if (snap_q.y <= PLAYER_Y_W'(GOAL_Y)) begin
                    level_d   = level_q + LEVEL_W'(1);
                    respawn_d = 1'b1;
                    if (level_d == LEVEL_W'(MAX_LEVEL)) begin
                        state_d = ST_WIN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= ST_IDLE;
            snap_q       <= '0;
            hit_q        <= 1'b0;
            idx_q        <= '0;
            lives_q      <= '0;
            level_q      <= '0;
            grace_q      <= '0;
            hit_pulse_q  <= 1'b0;
            respawn_q    <= 1'b0;
            game_state_q <= GS_IDLE;
            invuln_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            hit_q        <= hit_d;
            idx_q        <= idx_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            grace_q      <= grace_d;
            hit_pulse_q  <= hit_pulse_d;
            respawn_q    <= respawn_d;
            game_state_q <= report_state(state_d);
            invuln_q     <= (grace_d != '0);
            busy_q       <= (state_d == ST_SCAN) || (state_d == ST_RESOLVE);
        end
    end

    assign o_Game_State = game_state_q;
    assign o_Lives      = lives_q;
    assign o_Level      = level_q;
    assign o_Hit        = hit_pulse_q;
    assign o_Respawn    = respawn_q;
    assign o_Invuln     = invuln_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_hazard_round_ctrl.sv
// Self-checking bench for hazard_round_ctrl: frame-level behavioural model
// compared every cycle, plus directed literal expectations.
module tb_hazard_round_ctrl;

    localparam int N       = 6;
    localparam int CW      = 32;
    localparam int CH      = 32;
    localparam int PW      = 32;
    localparam int PH      = 32;
    localparam int START_L = 3;
    localparam int MAX_L   = 9;
    localparam int GRACE   = 60;
    localparam int GOAL    = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic tick = 1'b0;
    int   player_x = 0;
    int   player_y = 300;
    int   car_x [N];
    int   car_y [N];
    logic [9:0]     player_x_v, player_y_v;
    logic [N*10-1:0] car_x_bus;
    logic [N*9-1:0]  car_y_bus;

    logic [1:0] o_game_state;
    logic [3:0] o_lives, o_level;
    logic       o_hit, o_respawn, o_invuln, o_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign player_x_v = 10'(player_x);
    assign player_y_v = 10'(player_y);

    always_comb begin
        car_x_bus = '0;
        car_y_bus = '0;
        for (int k = 0; k < N; k++) begin
            car_x_bus[k*10 +: 10] = 10'(car_x[k]);
            car_y_bus[k*9 +: 9]   = 9'(car_y[k]);
        end
    end

    hazard_round_ctrl #(
        .N_CARS(N), .CAR_W(CW), .CAR_H(CH), .PLAYER_W(PW), .PLAYER_H(PH),
        .START_LIVES(START_L), .MAX_LEVEL(MAX_L), .GRACE_FRAMES(GRACE), .GOAL_Y(GOAL)
    ) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Start      (start),
        .i_Frame_Tick (tick),
        .i_Player_X   (player_x_v),
        .i_Player_Y   (player_y_v),
        .i_Car_X      (car_x_bus),
        .i_Car_Y      (car_y_bus),
        .o_Game_State (o_game_state),
        .o_Lives      (o_lives),
        .o_Level      (o_level),
        .o_Hit        (o_hit),
        .o_Respawn    (o_respawn),
        .o_Invuln     (o_invuln),
        .o_Busy       (o_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 running, 2 win, 3 over; a frame's
    // outcome is decided from the inputs at tick time and lands N+1 edges later.
    int m_mode = 0, m_lives = 0, m_level = 0, m_grace = 0, m_busy = 0;
    int m_hit = 0, m_resp = 0, p_hit = 0, p_goal = 0;

    function automatic int any_overlap(input int px, input int py);
        int r = 0;
        for (int k = 0; k < N; k++)
            if (px < car_x[k] + CW && px + PW > car_x[k] &&
                py < car_y[k] + CH && py + PH > car_y[k]) r = 1;
        return r;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mode = 0; m_lives = 0; m_level = 0; m_grace = 0;
            m_busy = 0; m_hit = 0; m_resp = 0;
        end else begin
            m_hit = 0;
            m_resp = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    if (p_hit != 0 && m_grace == 0) begin
                        m_lives--;
                        m_hit = 1;
                        if (m_lives == 0) m_mode = 3;
                        else begin m_resp = 1; m_grace = GRACE; end
                    end else if (p_goal != 0) begin
                        m_level++;
                        m_resp = 1;
                        if (m_level == MAX_L) m_mode = 2;
                    end
                end
            end else if (m_mode == 1) begin
                if (tick) begin
                    if (m_grace > 0) m_grace--;
                    p_hit  = any_overlap(player_x, player_y);
                    p_goal = (player_y <= GOAL) ? 1 : 0;
                    m_busy = N + 1;
                end
            end else if (start) begin
                m_mode = 1; m_lives = START_L; m_level = 0; m_grace = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("game_state", int'(o_game_state), m_mode);
        check("lives",      int'(o_lives),      m_lives);
        check("level",      int'(o_level),      m_level);
        check("hit",        int'(o_hit),        m_hit);
        check("respawn",    int'(o_respawn),    m_resp);
        check("invuln",     int'(o_invuln),     (m_grace != 0) ? 1 : 0);
        check("busy",       int'(o_busy),       (m_busy > 0) ? 1 : 0);
    end

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // One frame: tick, then watch the scan window; extra>0 re-ticks mid-scan.
    task automatic frame(input int px, input int py, input int extra,
                         output int hits, output int resps, output int hit_at);
        player_x = px;
        player_y = py;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        hits = 0; resps = 0; hit_at = -1;
        for (int k = 2; k <= N + 3; k++) begin
            @(negedge clk);
            if (o_hit) begin
                hits++;
                if (hit_at < 0) hit_at = k;
            end
            if (o_respawn) resps++;
            tick = (k == extra) ? 1'b1 : 1'b0;
        end
        tick = 1'b0;
    endtask

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : (v > hi) ? hi : v;
    endfunction

    initial begin
        int h, r, a, f_hit, px, py, j, sel, extra;
        for (int k = 0; k < N; k++) begin
            car_x[k] = 100 * k + 50;
            car_y[k] = 300;
        end

        repeat (3) @(negedge clk);
        check("reset_state", int'(o_game_state), 0);
        check("reset_lives", int'(o_lives), 0);
        check("reset_busy",  int'(o_busy), 0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);

        start_pulse();
        check("start_state", int'(o_game_state), 1);
        check("start_lives", int'(o_lives), START_L);
        check("start_level", int'(o_level), 0);

        frame(450, 300, 0, h, r, a);
        check("first_hit_latency", a, N + 2);
        check("first_hit_lives", int'(o_lives), 2);
        check("first_hit_invuln", int'(o_invuln), 1);
        check("first_hit_respawn", r, 1);

        f_hit = 0;
        for (int f = 1; f <= GRACE + 5 && f_hit == 0; f++) begin
            frame(450, 300, 0, h, r, a);
            if (h > 0) f_hit = f;
        end
        check("grace_frames", f_hit, GRACE);
        check("grace_lives", int'(o_lives), 1);

        f_hit = 0;
        for (int f = 1; f <= GRACE + 5 && f_hit == 0; f++) begin
            frame(450, 300, 0, h, r, a);
            if (h > 0) f_hit = f;
        end
        check("over_no_respawn", r, 0);
        check("over_state", int'(o_game_state), 3);
        check("over_lives", int'(o_lives), 0);

        start_pulse();
        for (int l = 1; l <= MAX_L; l++) begin
            frame(800, 0, 0, h, r, a);
            check("goal_respawn", r, 1);
            check("goal_level", int'(o_level), l);
        end
        check("win_state", int'(o_game_state), 2);

        start_pulse();
        car_y[0] = 0;
        frame(50, 0, 0, h, r, a);
        check("hit_beats_goal_hit", h, 1);
        check("hit_beats_goal_level", int'(o_level), 0);
        frame(50, 0, 0, h, r, a);
        check("grace_hit_goal_hit", h, 0);
        check("grace_hit_goal_level", int'(o_level), 1);
        car_y[0] = 300;

        reset_pulse();
        start_pulse();
        frame(282, 300, 0, h, r, a);
        check("abut_32_miss", h, 0);
        car_x[5] = 1000;
        frame(968, 300, 0, h, r, a);
        check("abut_1000_miss", h, 0);
        frame(281, 300, 0, h, r, a);
        check("abut_31_hit", h, 1);
        reset_pulse();
        start_pulse();
        frame(1023, 300, 0, h, r, a);
        check("wrap_safe_hit", h, 1);
        car_x[5] = 550;

        reset_pulse();
        start_pulse();
        player_x = 450;
        player_y = 300;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("midscan_reset_state", int'(o_game_state), 0);
        check("midscan_reset_busy", int'(o_busy), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        h = 0; r = 0;
        for (int k = 0; k < N + 4; k++) begin
            @(negedge clk);
            h += int'(o_hit);
            r += int'(o_respawn);
        end
        check("midscan_reset_no_hit", h, 0);
        check("midscan_reset_no_respawn", r, 0);

        start_pulse();
        frame(450, 300, 2, h, r, a);
        check("dropped_tick_latency", a, N + 2);
        check("dropped_tick_single_hit", h, 1);

        for (int f = 0; f < 200; f++) begin
            if (m_mode != 1) start_pulse();
            else if ($urandom_range(0, 9) == 0) start_pulse();
            for (int k = 0; k < N; k++) begin
                car_x[k] = int'($urandom_range(0, 1023));
                car_y[k] = int'($urandom_range(0, 511));
            end
            j   = int'($urandom_range(0, N - 1));
            px  = clamp(car_x[j] + int'($urandom_range(0, 80)) - 40, 1023);
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      py = 0;
            else if (sel == 3) py = int'($urandom_range(0, 1023));
            else               py = clamp(car_y[j] + int'($urandom_range(0, 80)) - 40, 1023);
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, N + 1)) : 0;
            frame(px, py, extra, h, r, a);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
